keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 162 ++++++++++++++++
 tb/tb_keypad_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks active-low rows, debounces a single pressed key,
// reports its code with a one-cycle flag, and debounces the release before resuming the scan.
module keypad_scan #(
    parameter int SCAN_HOLD = 4,
    parameter int DEBOUNCE  = 10
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_value,
    output logic       flag,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(SCAN_HOLD - 1);
    localparam logic [7:0] DEB_TGT   = 8'(DEBOUNCE);

    state_t     state_q, state_d;
    logic [3:0] sync1_q, col_s_q;
    logic [1:0] row_q, row_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] deb_q, deb_d;
    logic [3:0] pat_q, pat_d;
    logic [1:0] key_col_q, key_col_d;
    logic [3:0] key_value_q, key_value_d;
    logic       flag_q, flag_d;
    logic [7:0] deb_inc;
    logic       one_low;
    logic [1:0] low_idx;

    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (col_s_q)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign deb_inc = (deb_q == 8'hFF) ? deb_q : deb_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        hold_d      = hold_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        key_col_d   = key_col_q;
        key_value_d = key_value_q;
        flag_d      = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (hold_q >= HOLD_LAST) begin
                    hold_d = 4'd0;
                    if (one_low) begin
                        pat_d     = col_s_q;
                        key_col_d = low_idx;
                        deb_d     = 8'd1;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
                end
            end
            S_DEBOUNCE: begin
                if (col_s_q == pat_q) begin
                    deb_d = deb_inc;
                    if (deb_inc >= DEB_TGT) begin
                        state_d     = S_PRESSED;
                        flag_d      = 1'b1;
                        key_value_d = {row_q, key_col_q};
                    end
                end else begin
                    state_d = S_SCAN;
                    row_d   = row_q + 2'd1;
                    hold_d  = 4'd0;
                    deb_d   = 8'd0;
                end
            end
            S_PRESSED: begin
                if (col_s_q == 4'hF) begin
                    state_d = S_RELEASE;
                    deb_d   = 8'd0;
                end
            end
            S_RELEASE: begin
                // Any low column during release is bounce: fall back without a new flag.
                if (col_s_q == 4'hF) begin
                    deb_d = deb_inc;
                    if (deb_inc >= DEB_TGT) begin
                        state_d = S_SCAN;
                        row_d   = row_q + 2'd1;
                        hold_d  = 4'd0;
                        deb_d   = 8'd0;
                    end
                end else begin
                    state_d = S_PRESSED;
                    deb_d   = 8'd0;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            state_q     <= S_SCAN;
            sync1_q     <= 4'hF;
            col_s_q     <= 4'hF;
            row_q       <= 2'd0;
            hold_q      <= 4'd0;
            deb_q       <= 8'd0;
            pat_q       <= 4'hF;
            key_col_q   <= 2'd0;
            key_value_q <= 4'd0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= col_in;
            col_s_q     <= sync1_q;
            row_q       <= row_d;
            hold_q      <= hold_d;
            deb_q       <= deb_d;
            pat_q       <= pat_d;
            key_col_q   <= key_col_d;
            key_value_q <= key_value_d;
            flag_q      <= flag_d;
        end
    end

    // Row drive follows the row index, which stays put outside SCAN.
    always_comb begin
        row_out = 4'hF;
        case (row_q)
            2'd0: row_out = 4'b1110;
            2'd1: row_out = 4'b1101;
            2'd2: row_out = 4'b1011;
            2'd3: row_out = 4'b0111;
            default: row_out = 4'hF;
        endcase
    end

    assign key_value = key_value_q;
    assign flag      = flag_q;
    assign busy      = (state_q != S_SCAN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a combinational keypad model driven by a key mask,
// with immediate-assertion checks along a linear sequence of scenarios.
module tb_keypad_scan;

    logic       CLK_1K = 1'b0;
    logic       RST;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_value;
    logic       flag;
    logic       busy;
    logic [1:0] dbg_state;

    logic [15:0] keys;
    int checks   = 0;
    int errors   = 0;
    int flag_cnt = 0;
    logic prev_flag = 1'b0;

    keypad_scan #(.SCAN_HOLD(4), .DEBOUNCE(10)) dut (
        .CLK_1K   (CLK_1K),
        .RST      (RST),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_value(key_value),
        .flag     (flag),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    always #5 CLK_1K = ~CLK_1K;

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK_1K) begin
        if (flag === 1'b1) begin
            flag_cnt++;
            chk("flag_not_consecutive", {31'd0, prev_flag}, 32'd0);
        end
        prev_flag = flag;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_1K);
    endtask

    task automatic wait_flag(input string tag, input int max, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < max) begin
            @(negedge CLK_1K);
            n++;
            if (flag === 1'b1) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        logic idle;
        int n;
        idle = 1'b0;
        n = 0;
        while (!idle && n < max) begin
            @(negedge CLK_1K);
            n++;
            if (busy === 1'b0) idle = 1'b1;
        end
        chk(tag, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        int n;
        int f0;
        int row_changes;
        logic busy_any;
        logic [3:0] exp_row;
        logic [3:0] last_row;

        RST  = 1'b0;
        keys = 16'h0000;
        cyc(3);
        chk("rst_row_out", row_out, 4'b1110);
        chk("rst_key_value", key_value, 4'h0);
        chk("rst_flag", flag, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        RST = 1'b1;

        // Idle scan: each row held four cycles, rows walk 0,1,2,3,0.
        cyc(3);
        chk("scan_row0_held", row_out, 4'b1110);
        cyc(1);
        chk("scan_row1_start", row_out, 4'b1101);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            exp_row = 4'hF;
            exp_row[(1 + (i + 1) / 4) % 4] = 1'b0;
            chk("scan_row_walk", row_out, exp_row);
        end

        // Two columns low on row0: rejected, scan keeps moving.
        f0 = flag_cnt;
        keys = 16'h000C;
        busy_any = 1'b0;
        row_changes = 0;
        last_row = row_out;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (busy) busy_any = 1'b1;
            if (row_out != last_row) row_changes++;
            last_row = row_out;
        end
        chk("multi_busy_low", busy_any, 1'b0);
        chk("multi_no_flag", flag_cnt - f0, 0);
        chk("multi_scan_moves", row_changes >= 8, 1);
        keys = 16'h0000;
        cyc(10);

        // Key 6 held for 30 cycles, then released.
        f0 = flag_cnt;
        keys = 16'h0040;
        wait_flag("k6_flag_seen", 60, n);
        chk("k6_key_value", key_value, 4'h6);
        chk("k6_busy", busy, 1'b1);
        chk("k6_state_pressed", dbg_state, 2'd2);
        cyc(1);
        chk("k6_flag_one_cycle", flag, 1'b0);
        if (n + 1 < 30) cyc(30 - n - 1);
        keys = 16'h0000;
        cyc(12);
        chk("k6_busy_during_release", busy, 1'b1);
        cyc(1);
        chk("k6_busy_after_release", busy, 1'b0);
        chk("k6_resume_row2", row_out, 4'b1011);
        chk("k6_one_flag", flag_cnt - f0, 1);

        // Key 9 bounces, then settles.
        f0 = flag_cnt;
        keys = 16'h0200;
        cyc(3);
        keys = 16'h0000;
        cyc(3);
        keys = 16'h0200;
        cyc(3);
        keys = 16'h0000;
        cyc(3);
        chk("k9_bounce_no_flag", flag_cnt - f0, 0);
        keys = 16'h0200;
        wait_flag("k9_flag_seen", 60, n);
        chk("k9_key_value", key_value, 4'h9);
        keys = 16'h0000;
        wait_idle("k9_idle", 40);
        cyc(2);
        chk("k9_one_flag", flag_cnt - f0, 1);

        // Key e held, key 1 pressed on top of it: ignored.
        f0 = flag_cnt;
        keys = 16'h4000;
        wait_flag("ke_flag_seen", 60, n);
        chk("ke_key_value", key_value, 4'hE);
        cyc(3);
        keys = 16'h4002;
        cyc(30);
        chk("ke_second_key_no_flag", flag_cnt - f0, 1);
        chk("ke_value_kept", key_value, 4'hE);
        chk("ke_busy_held", busy, 1'b1);
        keys = 16'h0000;
        wait_idle("ke_idle", 40);
        cyc(5);
        chk("ke_no_flag_after", flag_cnt - f0, 1);

        // Key 5 with a bouncing release.
        f0 = flag_cnt;
        keys = 16'h0020;
        wait_flag("k5_flag_seen", 60, n);
        chk("k5_key_value", key_value, 4'h5);
        cyc(5);
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0000 : 16'h0020;
            cyc(1);
        end
        keys = 16'h0000;
        wait_idle("k5_idle", 60);
        chk("k5_resume_row2", row_out, 4'b1011);
        chk("k5_one_flag", flag_cnt - f0, 1);
        chk("k5_value_kept", key_value, 4'h5);
        cyc(4);
        chk("k5_scan_row3", row_out, 4'b0111);

        // Reset while key b is held: press discarded, then re-accepted once.
        f0 = flag_cnt;
        keys = 16'h0800;
        wait_flag("kb_flag_seen", 60, n);
        chk("kb_key_value", key_value, 4'hB);
        cyc(5);
        RST = 1'b0;
        #1;
        chk("kb_rst_row_out", row_out, 4'b1110);
        chk("kb_rst_key_value", key_value, 4'h0);
        chk("kb_rst_flag", flag, 1'b0);
        chk("kb_rst_busy", busy, 1'b0);
        chk("kb_rst_state", dbg_state, 2'd0);
        cyc(3);
        RST = 1'b1;
        wait_flag("kb_reflag_seen", 80, n);
        chk("kb_reflag_value", key_value, 4'hB);
        cyc(3);
        chk("kb_two_flags_total", flag_cnt - f0, 2);
        keys = 16'h0000;
        wait_idle("kb_idle", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
